bit_serializer: RTL

Parallel-to-serial front end that feeds the 101 sequence detector's data_in bit stream.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Shifts each word out one bit per clock on data_out, with a bit_valid qualifier and a last-bit marker.
- An optional inter-word gap drives 0, which deliberately breaks sequence matches that span words.
- With GAP=0, words stream contiguously, so detections can span word boundaries.

---
 rtl/bit_serializer_pkg.sv | 14 +
 rtl/bit_serializer_if.sv | 34 +++
 rtl/bit_serializer.sv | 119 +++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the parallel-to-serial front end that feeds
// the 101 sequence detector.
package bit_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } ser_state_e;

   localparam int DEFAULT_WIDTH     = 8;
   localparam bit MSB_FIRST_DEFAULT = 1'b1;

endpackage : bit_serializer_pkg

// File: rtl/bit_serializer_if.sv
// Word-side handshake plus serial-side outputs of the bit serializer.
interface bit_serializer_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] word_in;
   logic             word_valid;
   logic             word_ready;
   logic             data_out;
   logic             bit_valid;
   logic             last_bit;
   logic             busy;

   modport master (
      output word_in,
      output word_valid,
      input  word_ready,
      input  data_out,
      input  bit_valid,
      input  last_bit,
      input  busy
   );

   modport slave (
      input  word_in,
      input  word_valid,
      output word_ready,
      output data_out,
      output bit_valid,
      output last_bit,
      output busy
   );

endinterface : bit_serializer_if

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: accepts WIDTH-bit words on valid/ready and
// emits one registered bit per clock, with optional zero gap after each word.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int GAP       = 0,
   parameter bit MSB_FIRST = MSB_FIRST_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   bit_serializer_if.slave bus
);

   localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [7:0]    GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

   ser_state_e       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [7:0]       gap_q,   gap_d;
   logic             data_q,  data_d;
   logic             bvld_q,  bvld_d;
   logic             last_q,  last_d;
   logic             accept;
   logic             load;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Drops the bit just presented so the next one sits at the head.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   assign bus.word_ready = !reset &&
                           ((state_q == ST_IDLE) ||
                            ((GAP == 0) && (state_q == ST_SHIFT) && last_q));
   assign accept         = bus.word_valid && bus.word_ready;

   assign bus.data_out  = data_q;
   assign bus.bit_valid = bvld_q;
   assign bus.last_bit  = last_q;
   assign bus.busy      = (state_q != ST_IDLE);

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      data_d  = 1'b0;
      bvld_d  = 1'b0;
      last_d  = 1'b0;
      load    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) load = 1'b1;
         end
         ST_SHIFT: begin
            if (last_q) begin
               if (GAP > 0) begin
                  state_d = ST_GAP;
                  gap_d   = GAP_LOAD;
               end else if (accept) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d   = cnt_q + CW'(1);
               data_d  = first_bit(shreg_q);
               shreg_d = advance(shreg_q);
               bvld_d  = 1'b1;
               last_d  = (cnt_d == CNT_LAST);
            end
         end
         ST_GAP: begin
            if (gap_q == 8'd0) state_d = ST_IDLE;
            else               gap_d   = gap_q - 8'd1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Loading presents the first bit right away; a back-to-back load from
      // SHIFT therefore leaves no bubble between words.
      if (load) begin
         state_d = ST_SHIFT;
         cnt_d   = '0;
         data_d  = first_bit(bus.word_in);
         shreg_d = advance(bus.word_in);
         bvld_d  = 1'b1;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         data_q  <= 1'b0;
         bvld_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         bvld_q  <= bvld_d;
         last_q  <= last_d;
      end
   end

endmodule : bit_serializer
